// File: rtl/iddr_x8_deser.sv
// Purpose: 1:16 DDR input deserializer with one-bit-per-request word alignment (bitslip).
// Latency: a word's newest bit is shifted in and the word presented on the same ECLK rising edge; VALID pulses once every 8 ECLK.
// Backpressure: none; the serial stream free-runs, and slip requests arriving inside the guard window are dropped.
module iddr_x8_deser #(
    parameter int SLIP_GUARD = 4
) (
    input  logic ECLK,
    input  logic RSTN,
    input  logic D,
    input  logic ALIGNWD,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q4,
    output logic Q5,
    output logic Q6,
    output logic Q7,
    output logic Q8,
    output logic Q9,
    output logic Q10,
    output logic Q11,
    output logic Q12,
    output logic Q13,
    output logic Q14,
    output logic Q15,
    output logic VALID,
    output logic ALIGN_BUSY
);

    localparam logic [3:0] GUARD_INIT = 4'(SLIP_GUARD);

    logic        rise_cap;
    logic        fall_cap;
    // Only the newest 31 bits of history can ever fall inside a 16-bit window
    // at offsets 0..15, so older bits are not kept.
    logic [28:0] hist;
    logic [30:0] hist_nxt;
    logic [2:0]  cnt;
    logic [3:0]  slip;
    logic [3:0]  slip_nxt;
    logic [3:0]  guard;
    logic [3:0]  guard_nxt;
    logic        align_d;
    logic        slip_req;
    logic [15:0] word;
    logic        valid_r;
    logic        busy_r;

    // Even bit of each pair: sampled on the rising edge.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            rise_cap <= 1'b0;
        end else begin
            rise_cap <= D;
        end
    end

    // Odd bit of each pair: sampled on the falling edge that follows.
    always_ff @(negedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            fall_cap <= 1'b0;
        end else begin
            fall_cap <= D;
        end
    end

    // Post-shift history view; bit 0 is the newest bit in the stream.
    always_comb begin
        hist_nxt = {hist, rise_cap, fall_cap};
    end

    // Slip acceptance: a rising request edge only acts when the guard has expired.
    always_comb begin
        slip_req  = ALIGNWD & ~align_d;
        slip_nxt  = slip;
        guard_nxt = guard;
        if (slip_req && (guard == 4'd0)) begin
            slip_nxt  = slip + 4'd1;
            guard_nxt = GUARD_INIT;
        end else if (guard != 4'd0) begin
            guard_nxt = guard - 4'd1;
        end
    end

    // History shift, word cadence counter and slip/guard state.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            hist    <= '0;
            cnt     <= 3'd0;
            slip    <= 4'd0;
            guard   <= 4'd0;
            align_d <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            hist    <= hist_nxt[28:0];
            cnt     <= cnt + 3'd1;
            slip    <= slip_nxt;
            guard   <= guard_nxt;
            align_d <= ALIGNWD;
            busy_r  <= (guard_nxt != 4'd0);
        end
    end

    // Word load every eighth edge; uses the slip offset in force before this edge.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            word    <= '0;
            valid_r <= 1'b0;
        end else if (cnt == 3'd7) begin
            word    <= hist_nxt[slip +: 16];
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    // word[15] is the oldest bit of the window and maps to Q0.
    assign Q0  = word[15];
    assign Q1  = word[14];
    assign Q2  = word[13];
    assign Q3  = word[12];
    assign Q4  = word[11];
    assign Q5  = word[10];
    assign Q6  = word[9];
    assign Q7  = word[8];
    assign Q8  = word[7];
    assign Q9  = word[6];
    assign Q10 = word[5];
    assign Q11 = word[4];
    assign Q12 = word[3];
    assign Q13 = word[2];
    assign Q14 = word[1];
    assign Q15 = word[0];

    assign VALID      = valid_r;
    assign ALIGN_BUSY = busy_r;

endmodule

// File: tb/tb_iddr_x8_deser.sv
// Purpose: self-checking bench for iddr_x8_deser against a stream-level reference model.
// Latency: model predicts outputs after every ECLK rising edge; outputs sampled after the falling edge.
// Backpressure: not applicable; stimulus is a free-running serial stream.
module tb_iddr_x8_deser;

    localparam int SLIP_GUARD = 4;

    logic ECLK = 1'b0;
    logic RSTN = 1'b0;
    logic D = 1'b0;
    logic ALIGNWD = 1'b0;
    logic Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15;
    logic VALID;
    logic ALIGN_BUSY;
    logic [15:0] qv;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] pat = 16'hC3A5;

    iddr_x8_deser #(.SLIP_GUARD(SLIP_GUARD)) dut (
        .ECLK(ECLK), .RSTN(RSTN), .D(D), .ALIGNWD(ALIGNWD),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
        .Q8(Q8), .Q9(Q9), .Q10(Q10), .Q11(Q11), .Q12(Q12), .Q13(Q13), .Q14(Q14), .Q15(Q15),
        .VALID(VALID), .ALIGN_BUSY(ALIGN_BUSY)
    );

    assign qv = {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8, Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};

    always #5 ECLK = ~ECLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Reference model: the received stream as a list of bits, the word is a
    // 16-bit window of it ending S bits before the newest bit.
    logic        m_stream[$];
    logic        m_pa, m_pb, m_pal;
    int          m_k, m_s, m_last;
    logic [15:0] m_q;
    logic        m_valid, m_busy;

    task automatic model_reset();
        m_stream.delete();
        for (int i = 0; i < 32; i++) m_stream.push_back(1'b0);
        m_pa = 1'b0; m_pb = 1'b0; m_pal = 1'b0;
        m_k = 0; m_s = 0; m_last = -1000;
        m_q = '0; m_valid = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic abit, input logic bbit, input logic al);
        int n;
        m_stream.push_back(m_pa);
        m_stream.push_back(m_pb);
        while (m_stream.size() > 64) void'(m_stream.pop_front());
        n = m_stream.size();
        m_valid = (m_k % 8 == 7);
        if (m_valid) begin
            for (int j = 0; j < 16; j++) m_q[j] = m_stream[n - 16 - m_s + j];
        end
        if (al && !m_pal && (m_k - m_last > SLIP_GUARD)) begin
            m_s    = (m_s + 1) % 16;
            m_last = m_k;
        end
        m_busy = (m_k - m_last < SLIP_GUARD);
        m_pal = al; m_pa = abit; m_pb = bbit;
        m_k++;
    endtask

    // One ECLK cycle: abit is seen by the rising edge, bbit by the falling edge.
    task automatic step(input logic abit, input logic bbit, input logic al);
        D = abit;
        ALIGNWD = al;
        @(posedge ECLK);
        model_edge(abit, bbit, al);
        #1;
        D = bbit;
        @(negedge ECLK);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        RSTN = 1'b0; D = 1'b0; ALIGNWD = 1'b0;
        #1;
        @(posedge ECLK);
        @(negedge ECLK);
        #1;
        RSTN = 1'b1;
        model_reset();
    endtask

    // Random fill until the next edge starts a word, then the reference pattern.
    task automatic drive_pat_word();
        while (m_k % 8 != 7) step(rbit(), rbit(), 1'b0);
        for (int j = 0; j < 8; j++) step(pat[2*j], pat[2*j+1], 1'b0);
        step(rbit(), rbit(), 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (qv !== 16'h0000) begin n_fail++; $display("FAIL reset_q got=%h exp=%h", qv, 16'h0000); end
        n_tests++;
        if (VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", VALID); end
        n_tests++;
        if (ALIGN_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", ALIGN_BUSY); end
    endtask

    task automatic test_cadence();
        do_reset();
        for (int e = 0; e < 26; e++) begin
            step(1'b1, 1'b1, 1'b0);
            n_tests++;
            if (VALID !== ((e % 8) == 7)) begin
                n_fail++; $display("FAIL cadence_valid edge=%0d got=%b exp=%b", e, VALID, (e % 8) == 7);
            end
            if (e == 7) begin
                n_tests++;
                if (qv !== 16'hFFFC) begin n_fail++; $display("FAIL cadence_word0 got=%h exp=%h", qv, 16'hFFFC); end
            end
            if (e == 15) begin
                n_tests++;
                if (qv !== 16'hFFFF) begin n_fail++; $display("FAIL cadence_word1 got=%h exp=%h", qv, 16'hFFFF); end
            end
        end
    endtask

    task automatic test_data_order();
        do_reset();
        drive_pat_word();
        n_tests++;
        if (VALID !== 1'b1 || qv !== 16'hC3A5) begin
            n_fail++; $display("FAIL data_order valid=%b got=%h exp=%h", VALID, qv, 16'hC3A5);
        end
    endtask

    task automatic test_single_slip();
        int busy_cycles;
        busy_cycles = 0;
        do_reset();
        for (int e = 0; e < 7; e++) begin
            step(rbit(), (e == 6) ? 1'b1 : rbit(), (e == 2) ? 1'b1 : 1'b0);
            if (ALIGN_BUSY === 1'b1) busy_cycles++;
        end
        for (int j = 0; j < 8; j++) begin
            step(pat[2*j], pat[2*j+1], 1'b0);
            if (ALIGN_BUSY === 1'b1) busy_cycles++;
        end
        step(rbit(), rbit(), 1'b0);
        n_tests++;
        if (VALID !== 1'b1 || qv !== {pat[14:0], 1'b1}) begin
            n_fail++; $display("FAIL single_slip_word valid=%b got=%h exp=%h", VALID, qv, {pat[14:0], 1'b1});
        end
        n_tests++;
        if (busy_cycles != SLIP_GUARD) begin
            n_fail++; $display("FAIL single_slip_busy got=%0d cycles exp=%0d", busy_cycles, SLIP_GUARD);
        end
    endtask

    task automatic test_guard_wrap();
        int   rises;
        logic prev_busy;
        logic rose;
        rises = 0;
        prev_busy = 1'b0;
        do_reset();
        for (int e = 0; e < 7; e++) begin
            step(rbit(), rbit(), (e < 6) ? 1'b1 : 1'b0);
            if (ALIGN_BUSY === 1'b1 && prev_busy === 1'b0) rises++;
            prev_busy = ALIGN_BUSY;
        end
        for (int i = 0; i < 43; i++) begin
            step(rbit(), rbit(), 1'b1);
            rose = (ALIGN_BUSY === 1'b1 && prev_busy === 1'b0);
            if (rose) rises++;
            prev_busy = ALIGN_BUSY;
            n_tests++;
            if (rose !== ((i % 3) == 0)) begin
                n_fail++; $display("FAIL guard_pulse i=%0d accepted=%b exp=%b", i, rose, (i % 3) == 0);
            end
            step(rbit(), rbit(), 1'b0);
            if (ALIGN_BUSY === 1'b1 && prev_busy === 1'b0) rises++;
            prev_busy = ALIGN_BUSY;
        end
        n_tests++;
        if (rises != 16) begin n_fail++; $display("FAIL guard_total_slips got=%0d exp=16", rises); end
        drive_pat_word();
        n_tests++;
        if (VALID !== 1'b1 || qv !== 16'hC3A5) begin
            n_fail++; $display("FAIL wrap_word valid=%b got=%h exp=%h", VALID, qv, 16'hC3A5);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int e = 0; e < 6; e++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step(pat[2*j], pat[2*j+1], (j == 0) ? 1'b1 : 1'b0);
            if (j == 0) begin
                n_tests++;
                if (VALID !== 1'b1 || qv !== 16'h7FFC) begin
                    n_fail++; $display("FAIL simul_old_s valid=%b got=%h exp=%h", VALID, qv, 16'h7FFC);
                end
            end
        end
        step(rbit(), rbit(), 1'b0);
        n_tests++;
        if (VALID !== 1'b1 || qv !== {pat[14:0], 1'b0}) begin
            n_fail++; $display("FAIL simul_new_s valid=%b got=%h exp=%h", VALID, qv, {pat[14:0], 1'b0});
        end
    endtask

    task automatic test_random();
        logic al;
        do_reset();
        for (int e = 0; e < 240; e++) begin
            al = ($urandom_range(0, 3) == 0);
            step(rbit(), rbit(), al);
            n_tests++;
            if (qv !== m_q || VALID !== m_valid || ALIGN_BUSY !== m_busy) begin
                n_fail++;
                $display("FAIL random edge=%0d q=%h/%h valid=%b/%b busy=%b/%b",
                         e, qv, m_q, VALID, m_valid, ALIGN_BUSY, m_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int first;
        do_reset();
        for (int e = 0; e < 19; e++) step(1'b1, 1'b1, (e == 17) ? 1'b1 : 1'b0);
        n_tests++;
        if (qv !== m_q || ALIGN_BUSY !== 1'b1) begin
            n_fail++; $display("FAIL premid_state q=%h/%h busy=%b/1", qv, m_q, ALIGN_BUSY);
        end
        @(posedge ECLK);
        #2;
        RSTN = 1'b0;
        #1;
        n_tests++;
        if (qv !== 16'h0000) begin n_fail++; $display("FAIL midreset_q got=%h exp=0000", qv); end
        n_tests++;
        if (VALID !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got=%b exp=0", VALID); end
        n_tests++;
        if (ALIGN_BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", ALIGN_BUSY); end
        @(negedge ECLK);
        #1;
        RSTN = 1'b1;
        model_reset();
        first = -1;
        for (int e = 0; e < 20 && first < 0; e++) begin
            step(rbit(), rbit(), 1'b0);
            if (VALID === 1'b1) first = e;
        end
        n_tests++;
        if (first != 7) begin n_fail++; $display("FAIL midreset_first_valid got=%0d exp=7", first); end
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_data_order();
        test_single_slip();
        test_guard_wrap();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
